// File: rtl/sig_trans_pkg.sv
// rtl/sig_trans_pkg.sv - shared types and helpers for the transition rebuild block
package sig_trans_pkg;

  typedef enum logic [1:0] {
    WAIT_SEED = 2'd0,
    RUN       = 2'd1,
    FAULT     = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 12;

  // Fixed 64-bit input so any WIDTH up to 64 can call it after zero-extension.
  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] pc;
    pc = '0;
    for (int i = 0; i < 64; i++) begin
      pc = pc + 7'(v[i]);
    end
    return pc;
  endfunction

endpackage

// File: rtl/sig_trans_gap_mon.sv
// rtl/sig_trans_gap_mon.sv - per-bit toggle spacing counter and violation flag
module sig_trans_gap_mon #(
  parameter int MIN_GAP = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic advance,
  input  logic toggle,
  output logic viol
);

  localparam int GW = $clog2(MIN_GAP + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_GAP);

  logic [GW-1:0] gap_q, gap_d;

  // Counter only moves on consumed samples; it saturates at MIN_GAP.
  always_comb begin
    gap_d = gap_q;
    if (clear) begin
      gap_d = GAP_MAX;
    end else if (advance) begin
      if (toggle) begin
        gap_d = GW'(1);
      end else if (gap_q < GAP_MAX) begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  assign viol = advance & toggle & (gap_q < GAP_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q <= GAP_MAX;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/sig_trans_rebuild.sv
// rtl/sig_trans_rebuild.sv - rebuilds a signal from its transition vector, counts toggles, flags spacing faults
module sig_trans_rebuild
  import sig_trans_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MIN_GAP = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] In,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  output logic [CNT_W-1:0] trans_cnt,
  output logic             fault,
  output logic [WIDTH-1:0] fault_bits
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic [WIDTH-1:0] fault_bits_q, fault_bits_d;

  logic             consume;
  logic [WIDTH-1:0] viol;
  logic [CNT_W:0]   cnt_sum;

  // A seed in the same cycle discards the sample entirely.
  assign consume = (state_q == RUN) && in_valid && !seed_load;

  for (genvar i = 0; i < WIDTH; i++) begin : g_gap
    sig_trans_gap_mon #(
      .MIN_GAP (MIN_GAP)
    ) u_gap (
      .clk     (clk),
      .reset   (reset),
      .clear   (seed_load),
      .advance (consume),
      .toggle  (In[i]),
      .viol    (viol[i])
    );
  end

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(popcount(64'(In)));

  always_comb begin
    state_d      = state_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    fault_bits_d = fault_bits_q;
    if (seed_load) begin
      state_d      = RUN;
      out_d        = seed;
      out_valid_d  = 1'b1;
      fault_d      = 1'b0;
      fault_bits_d = '0;
    end else if (consume) begin
      out_d       = out_q ^ In;
      out_valid_d = 1'b1;
      cnt_d       = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      // The offending sample is still applied; only later samples are blocked.
      if (|viol) begin
        state_d      = FAULT;
        fault_d      = 1'b1;
        fault_bits_d = fault_bits_q | viol;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_SEED;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      cnt_q        <= '0;
      fault_q      <= 1'b0;
      fault_bits_q <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_bits_q <= fault_bits_d;
    end
  end

  assign Out        = out_q;
  assign out_valid  = out_valid_q;
  assign trans_cnt  = cnt_q;
  assign fault      = fault_q;
  assign fault_bits = fault_bits_q;

endmodule

// File: doc/sig_trans_rebuild.md
# sig_trans_rebuild

Receive-side counterpart of the signal transition detector. It takes the detector's per-bit transition vector, one sample per clock, and rebuilds the original 12-bit signal by toggling a seeded register. It also counts transitions and flags minimum-spacing violations, where a bit toggles faster than the channel allows. It sits downstream of the detector, or of a channel carrying its output, and closes the loop for end-to-end checking.

## Interface
- WIDTH, 12, signal and transition-vector width
- MIN_GAP, 2, minimum valid samples between two toggles of the same bit (≥1)
- CNT_W, 16, transition counter width
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; one clock; overrides every other input
- In  input  WIDTH  transition vector; bit i = 1 means bit i toggled in this sample
- in_valid  input  1  In carries a sample this cycle
- seed  input  WIDTH  initial signal value
- seed_load  input  1  load seed into the rebuild register
- Out  output  WIDTH  rebuilt signal
- out_valid  output  1  one-cycle pulse: Out was updated by a seed or a consumed sample
- trans_cnt  output  CNT_W  total toggles consumed, saturating
- fault  output  1  spacing violation latched
- fault_bits  output  WIDTH  sticky mask of offending bits

## Operation
- States:
  - WAIT_SEED: after reset; In and in_valid are ignored.
  - RUN: samples are consumed.
  - FAULT: Out is frozen and In is ignored.
- Reset values: state=WAIT_SEED, Out=0, out_valid=0, trans_cnt=0, fault=0, fault_bits=0, all gap counters=MIN_GAP.
- seed_load in any state:
  - Out←seed, next state RUN, out_valid=1.
  - gap counters←MIN_GAP; fault←0; fault_bits←0.
  - trans_cnt is kept (only reset clears it).
  - Has priority over in_valid in the same cycle; that In is discarded.
- RUN with in_valid=1 and seed_load=0:
  - Out←Out^In, out_valid=1.
  - trans_cnt←min(trans_cnt+popcount(In), 2^CNT_W−1).
- Per-bit gap counter g[i], counted over valid samples only:
  - When In[i]=1, g[i]←1.
  - Otherwise g[i]←min(g[i]+1, MIN_GAP).
- Violation: In[i]=1 while g[i]<MIN_GAP.
  - The offending sample is still applied to Out and trans_cnt.
  - fault←1; fault_bits|=offending mask; next state FAULT.
- RUN with in_valid=0: all state is held, out_valid=0. Gap counters do not advance.
- FAULT: only seed_load or reset leave it. out_valid=0 and trans_cnt is held.
- Popcount is WIDTH-wide, zero-extended to CNT_W before the add. Saturation is checked on the CNT_W+1-bit sum.

## Timing
- All outputs are registered.
- Out, out_valid and trans_cnt reflect a sample one clock after the edge where in_valid=1.
- fault and fault_bits assert on the same edge as the offending sample's Out update.
- Back-to-back samples are accepted every cycle; there is no backpressure.
- Reset asserted mid-stream: on the following edge all outputs take their reset values, whatever the other inputs are.
- seed_load and in_valid in the same cycle: the seed wins and In is discarded.
- With MIN_GAP=1 a violation can never occur.

## Structure
- Shared package sig_trans_pkg holds:
  - state enum: WAIT_SEED, RUN, FAULT
  - default WIDTH
  - popcount function
- Sub-module sig_trans_gap_mon holds one bit's gap counter and violation output. It is instantiated WIDTH times by generate.
- Top level holds the FSM, the Out register, the counter and the fault latches.

## Test plan
All scenarios use defaults unless noted.
- Reset, then seed=12'h0A5 with seed_load, then In=12'h001 valid → Out=12'h0A5 then 12'h0A4. out_valid pulses on both. trans_cnt=1.
- In=12'hFFF valid in WAIT_SEED → Out=0, trans_cnt=0, out_valid=0.
- Seed 0, then In=12'h010 on two consecutive valid cycles → Out=12'h010 then 12'h000. fault=1, fault_bits=12'h010, trans_cnt=2. A further In=12'h001 leaves Out=12'h000.
- Seed 0, then In=12'h010, 12'h000, 12'h010, all valid, with an in_valid=0 bubble between the first two → Out ends at 12'h000. fault=0, trans_cnt=2.
- CNT_W=4: seed 0, then In alternating 12'hFFF and 12'h000 → trans_cnt=12, then saturates at 15.
- While in RUN with Out=12'h00F:
  - seed_load with seed=12'h123 and In=12'hFFF valid in the same cycle → Out=12'h123 and trans_cnt unchanged.
  - Then assert reset mid-stream → all outputs return to their reset values on the next edge.
